// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: sequential instruction prefetcher with in-order queue and redirect squash
module ifetch_prefetch #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 4,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [15:0] o_inst,
  output logic [15:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic        i_mem_waitreq,
  input  logic [15:0] i_mem_rddata,
  input  logic        i_mem_rdvalid
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {RESET_IDLE, RUN, FLUSH_WAIT} state_t;
  state_t        state, state_nx;
  logic [15:0]   fetch_pc, ret_pc, stall_addr, redir_pc;
  logic [CW-1:0] count, outst, discard, outst_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   inst_q [DEPTH];
  logic [15:0]   pc_q [DEPTH];
  logic          acc, rsp, drop, push, pop;
  assign redir_pc     = {i_redirect_pc[15:1], 1'b0};
  assign o_mem_rd     = state != RESET_IDLE && ({1'b0, count} + {1'b0, outst}) < (CW+1)'(DEPTH)
                        && outst < CW'(MAX_OUTST);
  assign o_mem_addr   = state == FLUSH_WAIT ? stall_addr : fetch_pc;
  assign acc          = o_mem_rd && !i_mem_waitreq;
  assign rsp          = i_mem_rdvalid && outst != '0;
  assign drop         = rsp && discard != '0;
  assign push         = rsp && !drop && !i_redirect;
  assign o_inst_valid = count != '0;
  assign pop          = o_inst_valid && i_inst_ready && !i_redirect;
  assign outst_nx     = outst + CW'(acc) - CW'(rsp);
  assign o_inst       = o_inst_valid ? inst_q[rd_ptr] : '0;
  assign o_inst_pc    = o_inst_valid ? pc_q[rd_ptr] : '0;
  always_comb begin
    state_nx = state;
    state_nx = state == RESET_IDLE                        ? RUN :
               (i_redirect && o_mem_rd && i_mem_waitreq) ? FLUSH_WAIT :
               (state == FLUSH_WAIT && acc)              ? RUN : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RESET_IDLE;
      fetch_pc   <= RESET_PC;
      ret_pc     <= RESET_PC;
      stall_addr <= RESET_PC;
      count      <= '0;
      outst      <= '0;
      discard    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state <= state_nx;
      outst <= outst_nx;
      if (i_redirect) begin
        fetch_pc   <= redir_pc;
        ret_pc     <= redir_pc;
        stall_addr <= o_mem_addr;
        discard    <= outst_nx;
        count      <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (acc && state != FLUSH_WAIT) fetch_pc <= fetch_pc + 16'd2;
        if (push) ret_pc <= ret_pc + 16'd2;
        discard <= discard - CW'(drop) + CW'(acc && state == FLUSH_WAIT);
        count   <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= i_mem_rddata;
      pc_q[wr_ptr]   <= ret_pc;
    end
  end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: randomized bench with memory model and fetch-stream scoreboard
module tb_ifetch_prefetch;
  localparam int DEPTH = 4;
  localparam int MAX_OUTST = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
  logic        clk = 0;
  logic        reset = 1;
  logic        i_redirect = 0;
  logic [15:0] i_redirect_pc = 0;
  logic        o_inst_valid;
  logic [15:0] o_inst;
  logic [15:0] o_inst_pc;
  logic        i_inst_ready = 0;
  logic [15:0] o_mem_addr;
  logic        o_mem_rd;
  logic        i_mem_waitreq = 0;
  logic [15:0] i_mem_rddata = 0;
  logic        i_mem_rdvalid = 0;
  ifetch_prefetch #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc), .i_inst_ready(i_inst_ready),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .i_mem_waitreq(i_mem_waitreq),
    .i_mem_rddata(i_mem_rddata), .i_mem_rdvalid(i_mem_rdvalid)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int lat = 1;
  int wait_pct = 0;
  int ready_pct = 100;
  bit force_wait = 0;
  bit do_redir = 0;
  logic [15:0] redir_pc = 0;
  logic [15:0] mq_addr[$];
  int          mq_due[$];
  logic [15:0] pop_pcs[$];
  logic [15:0] acc_addrs[$];
  int cyc, first_acc, first_valid, n_acc;
  logic [15:0] exp_pc, exp_addr, held_addr, prev_addr, last_inst, last_pc;
  bit stale_hold, prev_stall, prev_redir, last_hold;
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5a3c;
  endfunction
  task automatic step();
    logic acc, pop;
    @(negedge clk);
    i_mem_waitreq = force_wait || ($urandom_range(99) < wait_pct);
    i_inst_ready = ($urandom_range(99) < ready_pct);
    i_redirect = do_redir;
    i_redirect_pc = redir_pc;
    do_redir = 0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      i_mem_rdvalid = 1;
      i_mem_rddata = mem_word(mq_addr[0]);
    end else begin
      i_mem_rdvalid = 0;
      i_mem_rddata = 16'($urandom);
    end
    #1;
    if (prev_stall) begin
      total++;
      if (o_mem_rd !== 1'b1 || o_mem_addr !== prev_addr) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d: rd=%b addr=%h, want rd=1 addr=%h", cyc, o_mem_rd, o_mem_addr, prev_addr);
      end
    end
    if (prev_redir) begin
      total++;
      if (o_inst_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_valid cyc=%0d: valid=%b, want 0", cyc, o_inst_valid);
      end
    end
    if (last_hold) begin
      total++;
      if (o_inst_valid !== 1'b1 || o_inst !== last_inst || o_inst_pc !== last_pc) begin
        bad++;
        $display("FAIL head_stable cyc=%0d: valid=%b inst=%h pc=%h, want 1 %h %h", cyc, o_inst_valid, o_inst, o_inst_pc, last_inst, last_pc);
      end
    end
    if (o_mem_rd === 1'b1) begin
      total++;
      if (mq_addr.size() >= MAX_OUTST) begin
        bad++;
        $display("FAIL credit cyc=%0d: rd=1 with outstanding=%0d, want <%0d", cyc, mq_addr.size(), MAX_OUTST);
      end
    end
    acc = o_mem_rd === 1'b1 && !i_mem_waitreq;
    pop = o_inst_valid === 1'b1 && i_inst_ready && !i_redirect;
    if (acc) begin
      total++;
      if (stale_hold) begin
        if (o_mem_addr !== held_addr) begin
          bad++;
          $display("FAIL stale_addr cyc=%0d: addr=%h, want %h", cyc, o_mem_addr, held_addr);
        end
        stale_hold = 0;
      end else begin
        if (o_mem_addr !== exp_addr) begin
          bad++;
          $display("FAIL issue_addr cyc=%0d: addr=%h, want %h", cyc, o_mem_addr, exp_addr);
        end
        exp_addr += 16'd2;
      end
      mq_addr.push_back(o_mem_addr);
      mq_due.push_back(cyc + lat);
      acc_addrs.push_back(o_mem_addr);
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (o_inst_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (pop) begin
      total++;
      if (o_inst_pc !== exp_pc || o_inst !== mem_word(exp_pc)) begin
        bad++;
        $display("FAIL pop_word cyc=%0d: pc=%h inst=%h, want pc=%h inst=%h", cyc, o_inst_pc, o_inst, exp_pc, mem_word(exp_pc));
      end
      exp_pc += 16'd2;
      pop_pcs.push_back(o_inst_pc);
    end
    if (i_mem_rdvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (i_redirect) begin
      exp_pc = {i_redirect_pc[15:1], 1'b0};
      exp_addr = exp_pc;
      if (o_mem_rd === 1'b1 && i_mem_waitreq) begin
        if (!stale_hold) held_addr = o_mem_addr;
        stale_hold = 1;
      end
    end
    prev_stall = o_mem_rd === 1'b1 && i_mem_waitreq;
    prev_addr = o_mem_addr;
    prev_redir = i_redirect;
    last_hold = o_inst_valid === 1'b1 && !i_inst_ready && !i_redirect;
    last_inst = o_inst;
    last_pc = o_inst_pc;
    cyc++;
  endtask
  task automatic late_pulse();
    if (mq_addr.size() > 0) begin
      i_mem_rdvalid = 1;
      i_mem_rddata = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else i_mem_rdvalid = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1;
    i_mem_rdvalid = 0;
    i_redirect = 0;
    i_inst_ready = 0;
    i_mem_waitreq = 0;
    #1;
    total++;
    if (o_mem_rd !== 1'b0 || o_mem_addr !== RESET_PC || o_inst_valid !== 1'b0 || o_inst !== 16'h0 || o_inst_pc !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: rd=%b addr=%h valid=%b inst=%h pc=%h, want 0 %h 0 0000 0000", o_mem_rd, o_mem_addr, o_inst_valid, o_inst, o_inst_pc, RESET_PC);
    end
    @(negedge clk);
    late_pulse();
    @(negedge clk);
    reset = 0;
    late_pulse();
    #1;
    total++;
    if (o_mem_rd !== 1'b0 || o_mem_addr !== RESET_PC || o_inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: rd=%b addr=%h valid=%b, want 0 %h 0", o_mem_rd, o_mem_addr, o_inst_valid, RESET_PC);
    end
    mq_addr.delete();
    mq_due.delete();
    pop_pcs.delete();
    acc_addrs.delete();
    exp_pc = RESET_PC;
    exp_addr = RESET_PC;
    stale_hold = 0;
    prev_stall = 0;
    prev_redir = 0;
    last_hold = 0;
    force_wait = 0;
    do_redir = 0;
    cyc = 0;
    first_acc = -1;
    first_valid = -1;
    n_acc = 0;
  endtask
  task automatic test_reset();
    lat = 1; wait_pct = 0; ready_pct = 100;
    do_reset();
    step();
    total++;
    if (o_mem_rd !== 1'b1 || o_mem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL first_issue: rd=%b addr=%h, want 1 %h", o_mem_rd, o_mem_addr, RESET_PC);
    end
  endtask
  task automatic test_sequential();
    lat = 1; wait_pct = 0; ready_pct = 100;
    do_reset();
    repeat (12) step();
    total++;
    if (first_acc != 0 || first_valid != first_acc + 2) begin
      bad++;
      $display("FAIL first_latency: accept=%0d valid=%0d, want 0 and 2", first_acc, first_valid);
    end
    total++;
    if (pop_pcs.size() != 10 || pop_pcs[0] !== 16'h0000 || pop_pcs[1] !== 16'h0002) begin
      bad++;
      $display("FAIL throughput: pops=%0d first=%h, want 10 pops from 0000", pop_pcs.size(), pop_pcs.size() > 0 ? pop_pcs[0] : 16'hxxxx);
    end
  endtask
  task automatic test_backpressure();
    lat = 1; wait_pct = 0; ready_pct = 0;
    do_reset();
    repeat (10) step();
    total++;
    if (n_acc != DEPTH || o_mem_rd !== 1'b0 || o_inst_pc !== 16'h0000) begin
      bad++;
      $display("FAIL fill_stop: accepts=%0d rd=%b head=%h, want %0d 0 0000", n_acc, o_mem_rd, o_inst_pc, DEPTH);
    end
    ready_pct = 100;
    repeat (10) step();
    total++;
    if (pop_pcs.size() < 4 || acc_addrs.size() < 5 || pop_pcs[0] !== 16'h0 || pop_pcs[1] !== 16'h2 ||
        pop_pcs[2] !== 16'h4 || pop_pcs[3] !== 16'h6 || acc_addrs[4] !== 16'h8) begin
      bad++;
      $display("FAIL drain_resume: pops=%0d accepts=%0d, want 0,2,4,6 then fetch 0008", pop_pcs.size(), acc_addrs.size());
    end
  endtask
  task automatic test_redirect_inflight();
    int n;
    lat = 3; wait_pct = 0; ready_pct = 100;
    do_reset();
    n = 0;
    while (mq_addr.size() != 3 && n < 30) begin
      step();
      n++;
    end
    total++;
    if (mq_addr.size() != 3) begin
      bad++;
      $display("FAIL inflight_setup: outstanding=%0d, want 3", mq_addr.size());
    end
    do_redir = 1;
    redir_pc = 16'h0100;
    step();
    pop_pcs.delete();
    repeat (15) step();
    total++;
    if (pop_pcs.size() == 0 || pop_pcs[0] !== 16'h0100) begin
      bad++;
      $display("FAIL redirect_pc: pops=%0d first=%h, want 0100", pop_pcs.size(), pop_pcs.size() > 0 ? pop_pcs[0] : 16'hxxxx);
    end
  endtask
  task automatic test_stalled_redirect();
    lat = 1; wait_pct = 0; ready_pct = 100;
    do_reset();
    repeat (3) step();
    do_redir = 1;
    redir_pc = 16'h0010;
    step();
    force_wait = 1;
    step();
    total++;
    if (o_mem_rd !== 1'b1 || o_mem_addr !== 16'h0010) begin
      bad++;
      $display("FAIL stall_setup: rd=%b addr=%h, want 1 0010", o_mem_rd, o_mem_addr);
    end
    do_redir = 1;
    redir_pc = 16'h0040;
    step();
    repeat (3) step();
    total++;
    if (o_mem_rd !== 1'b1 || o_mem_addr !== 16'h0010) begin
      bad++;
      $display("FAIL flush_hold: rd=%b addr=%h, want 1 0010", o_mem_rd, o_mem_addr);
    end
    acc_addrs.delete();
    pop_pcs.delete();
    force_wait = 0;
    repeat (10) step();
    total++;
    if (acc_addrs.size() < 2 || pop_pcs.size() == 0 || acc_addrs[0] !== 16'h0010 || acc_addrs[1] !== 16'h0040 || pop_pcs[0] !== 16'h0040) begin
      bad++;
      $display("FAIL stalled_redirect: accepts=%0d pops=%0d, want 0010 then 0040, first pc 0040", acc_addrs.size(), pop_pcs.size());
    end
  endtask
  task automatic test_wrap();
    lat = 1; wait_pct = 0; ready_pct = 100;
    do_reset();
    repeat (2) step();
    do_redir = 1;
    redir_pc = 16'hFFFF;
    step();
    pop_pcs.delete();
    acc_addrs.delete();
    repeat (8) step();
    total++;
    if (pop_pcs.size() < 2 || acc_addrs.size() < 2 || pop_pcs[0] !== 16'hFFFE || pop_pcs[1] !== 16'h0000 ||
        acc_addrs[0] !== 16'hFFFE || acc_addrs[1] !== 16'h0000) begin
      bad++;
      $display("FAIL wrap: pops=%0d accepts=%0d, want FFFE then 0000", pop_pcs.size(), acc_addrs.size());
    end
  endtask
  task automatic test_reset_midrun();
    int n;
    lat = 3; wait_pct = 0; ready_pct = 0;
    do_reset();
    n = 0;
    while (!(mq_addr.size() == 2 && o_inst_valid === 1'b1) && n < 30) begin
      step();
      n++;
    end
    total++;
    if (mq_addr.size() != 2 || o_inst_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrun_setup: outstanding=%0d valid=%b, want 2 1", mq_addr.size(), o_inst_valid);
    end
    do_reset();
    lat = 1; ready_pct = 100;
    repeat (8) step();
    total++;
    if (acc_addrs.size() == 0 || pop_pcs.size() == 0 || acc_addrs[0] !== RESET_PC || pop_pcs[0] !== RESET_PC) begin
      bad++;
      $display("FAIL restart: accepts=%0d pops=%0d, want fetch and first pc %h", acc_addrs.size(), pop_pcs.size(), RESET_PC);
    end
  endtask
  task automatic test_random();
    int pops0;
    do_reset();
    pops0 = 0;
    repeat (6) begin
      lat = $urandom_range(1, 4);
      wait_pct = $urandom_range(0, 50);
      ready_pct = $urandom_range(20, 100);
      repeat (300) begin
        if ($urandom_range(99) < 4) begin
          do_redir = 1;
          redir_pc = 16'($urandom);
        end
        step();
      end
    end
    pops0 = pop_pcs.size();
    total++;
    if (pops0 < 100) begin
      bad++;
      $display("FAIL random_progress: pops=%0d, want >=100", pops0);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_stalled_redirect();
    test_wrap();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
